// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - ALU reservation station with dual-CDB wakeup and lowest-index issue
module reservation_station #(
  parameter int RS_SIZE  = 8,
  parameter int RS_IDX_W = 3,
  parameter int ROB_ID_W = 5
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                _clear,
  input  logic                _rs_ready,
  input  logic [4:0]          _rs_type,
  input  logic [ROB_ID_W-1:0] _rs_rob_id,
  input  logic [31:0]         _rs_r1,
  input  logic [31:0]         _rs_r2,
  input  logic [31:0]         _rs_imm,
  input  logic                _rs_has_dep1,
  input  logic [ROB_ID_W-1:0] _rs_dep1,
  input  logic                _rs_has_dep2,
  input  logic [ROB_ID_W-1:0] _rs_dep2,
  output logic                _rs_full,
  input  logic                _alu_cdb_valid,
  input  logic [ROB_ID_W-1:0] _alu_cdb_rob_id,
  input  logic [31:0]         _alu_cdb_value,
  input  logic                _lsb_cdb_valid,
  input  logic [ROB_ID_W-1:0] _lsb_cdb_rob_id,
  input  logic [31:0]         _lsb_cdb_value,
  output logic                _alu_ready,
  output logic [4:0]          _alu_type,
  output logic [ROB_ID_W-1:0] _alu_rob_id,
  output logic [31:0]         _alu_r1,
  output logic [31:0]         _alu_r2,
  output logic [31:0]         _alu_imm
);

  // Full is raised one slot early so the decoder's registered dispatch still finds room.
  localparam logic [RS_IDX_W:0] FULL_MARK = (RS_IDX_W+1)'(RS_SIZE - 1);

  logic [RS_SIZE-1:0]  busy;
  logic [RS_SIZE-1:0]  q1_valid;
  logic [RS_SIZE-1:0]  q2_valid;
  logic [RS_SIZE-1:0]  ready;
  logic [4:0]          e_type [RS_SIZE];
  logic [ROB_ID_W-1:0] e_rob  [RS_SIZE];
  logic [ROB_ID_W-1:0] e_q1   [RS_SIZE];
  logic [ROB_ID_W-1:0] e_q2   [RS_SIZE];
  logic [31:0]         e_v1   [RS_SIZE];
  logic [31:0]         e_v2   [RS_SIZE];
  logic [31:0]         e_imm  [RS_SIZE];
  logic [RS_IDX_W:0]   count;
  logic [RS_IDX_W:0]   count_next;

  logic                issue_found;
  logic [RS_IDX_W-1:0] issue_idx;
  logic                free_found;
  logic [RS_IDX_W-1:0] free_idx;
  logic                dispatch_ok;

  logic                d1_pending;
  logic [31:0]         d1_value;
  logic                d2_pending;
  logic [31:0]         d2_value;

  assign ready       = busy & ~q1_valid & ~q2_valid;
  assign _rs_full    = (count >= FULL_MARK);
  assign dispatch_ok = _rs_ready && free_found;

  // Lowest-index ready entry is issued; lowest-index free entry is allocated (both from pre-edge state).
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = RS_IDX_W'(i);
      end
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = RS_IDX_W'(i);
      end
    end
  end

  // Operands of an incoming micro-op may be resolved by a CDB broadcast in the same cycle; ALU bus wins.
  always_comb begin
    d1_pending = _rs_has_dep1;
    d1_value   = _rs_r1;
    d2_pending = _rs_has_dep2;
    d2_value   = _rs_r2;
    if (_rs_has_dep1) begin
      if (_alu_cdb_valid && (_alu_cdb_rob_id == _rs_dep1)) begin
        d1_pending = 1'b0;
        d1_value   = _alu_cdb_value;
      end else if (_lsb_cdb_valid && (_lsb_cdb_rob_id == _rs_dep1)) begin
        d1_pending = 1'b0;
        d1_value   = _lsb_cdb_value;
      end
    end
    if (_rs_has_dep2) begin
      if (_alu_cdb_valid && (_alu_cdb_rob_id == _rs_dep2)) begin
        d2_pending = 1'b0;
        d2_value   = _alu_cdb_value;
      end else if (_lsb_cdb_valid && (_lsb_cdb_rob_id == _rs_dep2)) begin
        d2_pending = 1'b0;
        d2_value   = _lsb_cdb_value;
      end
    end
  end

  // Occupancy changes by +1 on accepted dispatch and -1 on issue.
  always_comb begin
    count_next = count;
    case ({dispatch_ok, issue_found})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Entry table, occupancy and issue register; clear beats dispatch/wakeup, stall freezes all but the pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy        <= '0;
      q1_valid    <= '0;
      q2_valid    <= '0;
      count       <= '0;
      _alu_ready  <= 1'b0;
      _alu_type   <= '0;
      _alu_rob_id <= '0;
      _alu_r1     <= '0;
      _alu_r2     <= '0;
      _alu_imm    <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        e_type[i] <= '0;
        e_rob[i]  <= '0;
        e_q1[i]   <= '0;
        e_q2[i]   <= '0;
        e_v1[i]   <= '0;
        e_v2[i]   <= '0;
        e_imm[i]  <= '0;
      end
    end else if (!rdy_in) begin
      _alu_ready <= 1'b0;
    end else if (_clear) begin
      busy       <= '0;
      count      <= '0;
      _alu_ready <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && q1_valid[i]) begin
          if (_alu_cdb_valid && (_alu_cdb_rob_id == e_q1[i])) begin
            e_v1[i]     <= _alu_cdb_value;
            q1_valid[i] <= 1'b0;
          end else if (_lsb_cdb_valid && (_lsb_cdb_rob_id == e_q1[i])) begin
            e_v1[i]     <= _lsb_cdb_value;
            q1_valid[i] <= 1'b0;
          end
        end
        if (busy[i] && q2_valid[i]) begin
          if (_alu_cdb_valid && (_alu_cdb_rob_id == e_q2[i])) begin
            e_v2[i]     <= _alu_cdb_value;
            q2_valid[i] <= 1'b0;
          end else if (_lsb_cdb_valid && (_lsb_cdb_rob_id == e_q2[i])) begin
            e_v2[i]     <= _lsb_cdb_value;
            q2_valid[i] <= 1'b0;
          end
        end
      end

      _alu_ready <= issue_found;
      if (issue_found) begin
        _alu_type       <= e_type[issue_idx];
        _alu_rob_id     <= e_rob[issue_idx];
        _alu_r1         <= e_v1[issue_idx];
        _alu_r2         <= e_v2[issue_idx];
        _alu_imm        <= e_imm[issue_idx];
        busy[issue_idx] <= 1'b0;
      end

      if (dispatch_ok) begin
        busy[free_idx]     <= 1'b1;
        e_type[free_idx]   <= _rs_type;
        e_rob[free_idx]    <= _rs_rob_id;
        e_imm[free_idx]    <= _rs_imm;
        e_v1[free_idx]     <= d1_value;
        e_v2[free_idx]     <= d2_value;
        q1_valid[free_idx] <= d1_pending;
        q2_valid[free_idx] <= d2_pending;
        e_q1[free_idx]     <= _rs_dep1;
        e_q2[free_idx]     <= _rs_dep2;
      end

      count <= count_next;
    end
  end

endmodule
